// File: rtl/ysyx_22040088_mem_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// datapath widths and the byte-strobe merge used by the storage array.
package ysyx_22040088_mem_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_WAIT = S_WAIT;
    localparam logic [1:0] ST_RESP = S_RESP;

    function automatic logic [XLEN-1:0] strb_merge(
        input logic [XLEN-1:0]   old_word,
        input logic [XLEN-1:0]   new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [XLEN-1:0] merged;
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ysyx_22040088_dmem_array.sv
// Single-port 64-bit word array with byte-strobe writes and a registered,
// clearable read port; the read register doubles as the response data.
module ysyx_22040088_dmem_array
    import ysyx_22040088_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              wr_en_i,
    input  logic [STRB_W-1:0] strb_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[idx_i] <= strb_merge(mem_q[idx_i], wdata_i, strb_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22040088_dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, response after
// LATENCY cycles, range-checked against [ADDR_BASE, ADDR_BASE+DEPTH_WORDS*8).
module ysyx_22040088_dmem_responder
    import ysyx_22040088_mem_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [STRB_W-1:0] req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int              IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] SPAN     = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]      CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              in_range_q, in_range_d;
    logic [STRB_W-1:0] wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              err_q, err_d;

    // Full-width offset: addresses below the base wrap to huge values and fail the check.
    logic [XLEN-1:0]   req_off;
    logic              req_in_range;
    logic [IDX_W-1:0]  req_idx;

    assign req_off      = req_addr - ADDR_BASE;
    assign req_in_range = req_off < SPAN;
    assign req_idx      = req_off[IDX_W+2:3];

    logic              enter_resp;
    logic              rsp_hs;
    logic              use_live;
    logic [IDX_W-1:0]  act_idx;
    logic              act_in_range;
    logic [STRB_W-1:0] act_wen;
    logic [XLEN-1:0]   act_wdata;
    logic              arr_wr_en;
    logic              arr_rd_en;
    logic              arr_rd_clr;

    // With LATENCY=1 the access happens on the accept edge, so take the live request.
    assign use_live     = (state_q == ST_IDLE);
    assign act_idx      = use_live ? req_idx      : idx_q;
    assign act_in_range = use_live ? req_in_range : in_range_q;
    assign act_wen      = use_live ? req_wen      : wen_q;
    assign act_wdata    = use_live ? req_wdata    : wdata_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        rsp_hs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d      = req_idx;
                    in_range_d = req_in_range;
                    wen_d      = req_wen;
                    wdata_d    = req_wdata;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rsp_hs  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            err_d = !act_in_range;
        end else if (rsp_hs) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wen_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign arr_wr_en  = enter_resp && act_in_range && (act_wen != '0);
    assign arr_rd_en  = enter_resp && act_in_range && (act_wen == '0);
    assign arr_rd_clr = (enter_resp && !arr_rd_en) || rsp_hs;

    ysyx_22040088_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx_i    (act_idx),
        .wr_en_i  (arr_wr_en),
        .strb_i   (act_wen),
        .wdata_i  (act_wdata),
        .rd_en_i  (arr_rd_en),
        .rd_clr_i (arr_rd_clr),
        .rdata_o  (rsp_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;

endmodule
